// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its array.
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_e;

  localparam int DMEM_REG_BITS = 32;
  localparam int DMEM_LANES    = DMEM_REG_BITS / 8;

  // Word accesses only: low address bits must be clear and the word must exist.
  function automatic logic dmem_addr_err(input logic [63:0] addr, input logic [63:0] mem_words);
    return (addr[1:0] != 2'b00) || (addr >= (mem_words << 2));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and the responder.
interface dmem_responder_if #(
  parameter int RegBits = dmem_pkg::DMEM_REG_BITS
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_we_i;
  logic [RegBits-1:0]     req_addr_i;
  logic [RegBits-1:0]     req_wdata_i;
  logic [RegBits/8-1:0]   req_be_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [RegBits-1:0]     rsp_rdata_o;
  logic                   rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word array with per-lane write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int RegBits  = DMEM_REG_BITS,
  parameter int MemWords = 1024,
  parameter int Lanes    = DMEM_LANES,
  parameter int IdxW     = $clog2(MemWords)
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [Lanes-1:0]   be_i,
  input  logic [IdxW-1:0]    idx_i,
  input  logic [RegBits-1:0] wdata_i,
  output logic [RegBits-1:0] rdata_o
);

  logic [RegBits-1:0] mem_q [MemWords];
  logic [RegBits-1:0] rdata_q;

  // Contents deliberately have no reset so stored data survives a core reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int l = 0; l < Lanes; l++) begin
          if (be_i[l]) begin
            mem_q[idx_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core data port: one request at a time, fixed wait
// states, then a response held until the core takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RegBits    = DMEM_REG_BITS,
  parameter int MemWords   = 1024,
  parameter int WaitStates = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int Lanes = RegBits / 8;
  localparam int IdxW  = $clog2(MemWords);
  localparam int CntW  = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WaitStates);

  dmem_state_e        state_q;
  logic [CntW-1:0]    cnt_q;
  logic               we_q;
  logic [RegBits-1:0] addr_q;
  logic [RegBits-1:0] wdata_q;
  logic [Lanes-1:0]   be_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic               rsp_rd_q;

  logic               addr_err;
  logic               access;
  logic [RegBits-1:0] arr_rdata;

  assign addr_err = dmem_addr_err(64'(addr_q), 64'(MemWords));
  assign access   = (state_q == WAIT) && (cnt_q == '0);

  // The array is addressed from the request latch during the last wait cycle,
  // so its registered read lands on the same edge the response goes valid.
  dmem_array #(
    .RegBits  (RegBits),
    .MemWords (MemWords),
    .Lanes    (Lanes),
    .IdxW     (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (access && !addr_err),
    .we_i    (we_q),
    .be_i    (be_q),
    .idx_i   (addr_q[IdxW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            we_q        <= bus.req_we_i;
            addr_q      <= bus.req_addr_i;
            wdata_q     <= bus.req_wdata_i;
            be_q        <= bus.req_be_i;
            cnt_q       <= CntLoad;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= addr_err;
            rsp_rd_q    <= !we_q && !addr_err;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  // Stores and errors return zero; the array output only matters for good loads.
  assign bus.rsp_rdata_o = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.RegBits(32)) bus2 ();
  dmem_responder_if #(.RegBits(32)) bus0 ();

  dmem_responder #(.RegBits(32), .MemWords(1024), .WaitStates(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2)
  );

  dmem_responder #(.RegBits(32), .MemWords(1024), .WaitStates(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdy(input bit s);
    return s ? 32'(bus0.req_ready_o) : 32'(bus2.req_ready_o);
  endfunction
  function automatic logic [31:0] vld(input bit s);
    return s ? 32'(bus0.rsp_valid_o) : 32'(bus2.rsp_valid_o);
  endfunction
  function automatic logic [31:0] rdat(input bit s);
    return s ? bus0.rsp_rdata_o : bus2.rsp_rdata_o;
  endfunction
  function automatic logic [31:0] rerr(input bit s);
    return s ? 32'(bus0.rsp_err_o) : 32'(bus2.rsp_err_o);
  endfunction

  task automatic drive(input bit s, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic rr);
    if (s) begin
      bus0.req_valid_i = v; bus0.req_we_i = we; bus0.req_addr_i = a;
      bus0.req_wdata_i = d; bus0.req_be_i = be; bus0.rsp_ready_i = rr;
    end else begin
      bus2.req_valid_i = v; bus2.req_we_i = we; bus2.req_addr_i = a;
      bus2.req_wdata_i = d; bus2.req_be_i = be; bus2.rsp_ready_i = rr;
    end
  endtask

  task automatic wait_valid(input bit s, output int lat);
    lat = 0;
    while (vld(s) != 32'd1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One request with rsp_ready held high; lat counts edges from acceptance to valid.
  task automatic xact(input bit s, input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy_pre"}, rdy(s), 32'd1);
    drive(s, 1'b1, we, a, d, be, 1'b1);
    @(posedge clk); #1;
    drive(s, 1'b0, ~we, ~a, ~d, ~be, 1'b1);
    chk({tag, ".rdy_busy"}, rdy(s), 32'd0);
    wait_valid(s, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, rdat(s), exp_rd);
    chk({tag, ".err"}, rerr(s), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, ".vld_post"}, vld(s), 32'd0);
    chk({tag, ".rdy_post"}, rdy(s), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #2 rst_n = 1'b0;
    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst.ready", rdy(s[0]), 32'd0);
      chk("rst.valid", vld(s[0]), 32'd0);
      chk("rst.rdata", rdat(s[0]), 32'd0);
      chk("rst.err",   rerr(s[0]), 32'd0);
    end
    #18;
    chk("rst.ready_held", rdy(1'b0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.ready2", rdy(1'b0), 32'd1);
    chk("rel.ready0", rdy(1'b1), 32'd1);

    xact(1'b0, "st10",   1'b1, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 3);
    xact(1'b0, "ld10",   1'b0, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 3);
    xact(1'b0, "st10p",  1'b1, 32'h10,   32'h00001234, 4'b0011, 32'h0,        1'b0, 3);
    xact(1'b0, "ld10p",  1'b0, 32'h10,   32'h0,        4'h0,    32'hDEAD1234, 1'b0, 3);
    xact(1'b0, "ld13",   1'b0, 32'h13,   32'h0,        4'h0,    32'h0,        1'b1, 3);
    xact(1'b0, "st0",    1'b1, 32'h0,    32'h11223344, 4'hF,    32'h0,        1'b0, 3);
    xact(1'b0, "st1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1, 3);
    xact(1'b0, "ld0",    1'b0, 32'h0,    32'h0,        4'h0,    32'h11223344, 1'b0, 3);

    // Backpressure: response must hold steady while rsp_ready stays low.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    wait_valid(1'b0, lat);
    chk("bp.lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.valid", vld(1'b0), 32'd1);
      chk("bp.rdata", rdat(1'b0), 32'hDEAD1234);
      chk("bp.ready", rdy(1'b0), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("bp.vld_post", vld(1'b0), 32'd0);
    chk("bp.rdy_post", rdy(1'b0), 32'd1);

    xact(1'b1, "ws0.st20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1);
    xact(1'b1, "ws0.ld20", 1'b0, 32'h20, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1);

    // Reset pulse while a store is still counting down: the store must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid.ready", rdy(1'b0), 32'd0);
    chk("mid.valid", vld(1'b0), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.rel_ready", rdy(1'b0), 32'd1);
    xact(1'b0, "mid.ld10",   1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0, 3);
    xact(1'b1, "mid.ws0ld",  1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
